// File: rtl/bram_test_pkg.sv
// Shared types and helpers for the block RAM test sequencer: state encoding,
// default geometry and the address-derived data pattern.
package bram_test_pkg;

  localparam int          DEF_ADDR_W       = 10;
  localparam int          DEF_DATA_W       = 16;
  localparam logic [15:0] DEF_PATTERN_SEED = 16'hA5C3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } seq_state_e;

  // Pattern is computed 32 bits wide so any DATA_W up to 32 can truncate it.
  function automatic logic [31:0] pattern_f(input logic [31:0] addr,
                                            input logic [31:0] seed);
    return addr ^ seed;
  endfunction

endpackage

// File: rtl/bram_test_chk_pipe.sv
// Valid+address delay line that lines up each issued read address with the
// RAM's read data; free-running so it drains even while clk_en is low.
module bram_test_chk_pipe #(
  parameter int ADDR_W = 10,
  parameter int STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_valid_i,
  input  logic [ADDR_W-1:0] push_addr_i,
  output logic              out_valid_o,
  output logic [ADDR_W-1:0] out_addr_o,
  output logic              empty_o
);

  logic [STAGES-1:0] valid_q;
  logic [ADDR_W-1:0] addr_q [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < STAGES; i++) addr_q[i] <= '0;
    end else begin
      valid_q[0] <= push_valid_i;
      addr_q[0]  <= push_addr_i;
      for (int i = 1; i < STAGES; i++) begin
        valid_q[i] <= valid_q[i-1];
        addr_q[i]  <= addr_q[i-1];
      end
    end
  end

  assign out_valid_o = valid_q[STAGES-1];
  assign out_addr_o  = addr_q[STAGES-1];
  assign empty_o     = ~|valid_q;

endmodule

// File: rtl/bram_test_seq.sv
// Write-then-readback test sequencer driven by the shared address counter.
// Optional BRAM_TEST_SEQ_INJECT_EN adds inject_err to corrupt one written word.
module bram_test_seq
  import bram_test_pkg::*;
#(
  parameter int                ADDR_W       = DEF_ADDR_W,
  parameter int                DATA_W       = DEF_DATA_W,
  parameter logic [DATA_W-1:0] PATTERN_SEED = DATA_W'(DEF_PATTERN_SEED),
  parameter int                READ_LAT     = 1,
  parameter int                ERR_W        = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_en,
  input  logic              start,
`ifdef BRAM_TEST_SEQ_INJECT_EN
  input  logic              inject_err,
`endif
  input  logic [ADDR_W-1:0] addr_in,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  seq_state_e        state_q;
  logic              wrEn_q, rdEn_q, busy_q, done_q, pass_q;
  logic [ADDR_W-1:0] wrAddr_q, rdAddr_q, firstErr_q, firstErr_d;
  logic [DATA_W-1:0] wrData_q;
  logic [ERR_W-1:0]  errCount_q, errCount_d;

  logic              pushValid, pipeValid, pipeEmpty, mismatch;
  logic [ADDR_W-1:0] pipeAddr;
  logic [DATA_W-1:0] wrPat, chkPat, wrDataNext;

  assign wrPat  = DATA_W'(pattern_f(32'(addr_in), 32'(PATTERN_SEED)));
  assign chkPat = DATA_W'(pattern_f(32'(pipeAddr), 32'(PATTERN_SEED)));

  assign pushValid = (state_q == ST_READ) && clk_en;

  bram_test_chk_pipe #(
    .ADDR_W (ADDR_W),
    .STAGES (READ_LAT + 1)
  ) u_chk_pipe (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_valid_i (pushValid),
    .push_addr_i  (addr_in),
    .out_valid_o  (pipeValid),
    .out_addr_o   (pipeAddr),
    .empty_o      (pipeEmpty)
  );

  assign mismatch = pipeValid && (rd_data != chkPat);

  // Only the first mismatch of a run latches its address; the count saturates.
  always_comb begin
    errCount_d = errCount_q;
    firstErr_d = firstErr_q;
    if (mismatch) begin
      if (errCount_q != '1) errCount_d = errCount_q + ERR_W'(1);
      if (errCount_q == '0) firstErr_d = pipeAddr;
    end
  end

`ifdef BRAM_TEST_SEQ_INJECT_EN
  logic injArm_q;
  logic writeNow;

  assign writeNow = clk_en && ((state_q == ST_SYNC && addr_in == '0) || state_q == ST_WRITE);

  // A pulse arriving on the consuming edge re-arms for the following write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          injArm_q <= 1'b0;
    else if (inject_err) injArm_q <= 1'b1;
    else if (writeNow)   injArm_q <= 1'b0;
  end

  assign wrDataNext = wrPat ^ DATA_W'(injArm_q);
`else
  assign wrDataNext = wrPat;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      wrEn_q     <= 1'b0;
      wrAddr_q   <= '0;
      wrData_q   <= '0;
      rdEn_q     <= 1'b0;
      rdAddr_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      errCount_q <= '0;
      firstErr_q <= '0;
    end else begin
      wrEn_q     <= 1'b0;
      rdEn_q     <= 1'b0;
      errCount_q <= errCount_d;
      firstErr_q <= firstErr_d;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q    <= ST_SYNC;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            errCount_q <= '0;
            firstErr_q <= '0;
          end
        end
        ST_SYNC: begin
          if (clk_en && addr_in == '0) begin
            state_q  <= ST_WRITE;
            wrEn_q   <= 1'b1;
            wrAddr_q <= addr_in;
            wrData_q <= wrDataNext;
          end
        end
        ST_WRITE: begin
          if (clk_en) begin
            wrEn_q   <= 1'b1;
            wrAddr_q <= addr_in;
            wrData_q <= wrDataNext;
            if (addr_in == LAST_ADDR) state_q <= ST_READ;
          end
        end
        ST_READ: begin
          if (clk_en) begin
            rdEn_q   <= 1'b1;
            rdAddr_q <= addr_in;
            if (addr_in == LAST_ADDR) state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (pipeEmpty) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (errCount_q == '0);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign wr_en          = wrEn_q;
  assign wr_addr        = wrAddr_q;
  assign wr_data        = wrData_q;
  assign rd_en          = rdEn_q;
  assign rd_addr        = rdAddr_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = errCount_q;
  assign first_err_addr = firstErr_q;

endmodule
